// File: rtl/event_decimator.sv
// Per-channel event decimator: counts rising edges of evt_in and emits a gated one-cycle
// fire pulse every N+1 edges (or on every edge / once, depending on channel mode).
module event_decimator #(
  parameter int unsigned NCH   = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         evt_in,
  input  logic                   pwm_onoff,
  input  logic                   int_onoff,
  input  logic                   carr_onoff,
  input  logic [2*NCH-1:0]       mode,
  input  logic [CNT_W*NCH-1:0]   event_count,
  input  logic [NCH-1:0]         rearm,
  input  logic [NCH-1:0]         pend_clr,
  output logic [NCH-1:0]         evt_out,
  output logic [CNT_W*NCH-1:0]   evt_cnt,
  output logic [NCH-1:0]         done,
  output logic [NCH-1:0]         pend,
  output logic                   irq
);

  typedef enum logic [1:0] {
    ModeDisabled = 2'd0,
    ModePass     = 2'd1,
    ModeDecimate = 2'd2,
    ModeOneshot  = 2'd3
  } mode_e;

  logic [NCH-1:0]       evt_prev_q;
  logic [2*NCH-1:0]     mode_q;
  logic [CNT_W*NCH-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]       done_q, done_d;
  logic [NCH-1:0]       pend_q, pend_d;
  logic [NCH-1:0]       evt_out_q, evt_out_d;
  logic                 irq_q, irq_d;
  logic [NCH-1:0]       term;
  logic                 gate;

  assign gate = pwm_onoff & int_onoff & carr_onoff;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_cur, cnt_nxt, n_val;
    logic [1:0]       mode_cur;
    logic             rise, done_nxt, term_nxt;

    assign cnt_cur  = cnt_q[i*CNT_W +: CNT_W];
    assign n_val    = event_count[i*CNT_W +: CNT_W];
    assign mode_cur = mode[2*i +: 2];
    assign rise     = evt_in[i] & ~evt_prev_q[i];

    always_comb begin
      cnt_nxt  = cnt_cur;
      done_nxt = done_q[i];
      term_nxt = 1'b0;
      // A mode switch or rearm restarts the channel and swallows any coincident rise.
      if ((mode_cur != mode_q[2*i +: 2]) || rearm[i]) begin
        cnt_nxt  = '0;
        done_nxt = 1'b0;
      end else begin
        unique case (mode_e'(mode_cur))
          ModeDisabled: begin
            cnt_nxt  = '0;
            done_nxt = 1'b0;
          end
          ModePass: begin
            cnt_nxt  = '0;
            done_nxt = 1'b0;
            term_nxt = rise;
          end
          ModeDecimate: begin
            if (rise) begin
              if (cnt_cur >= n_val) begin
                cnt_nxt  = '0;
                term_nxt = 1'b1;
              end else begin
                cnt_nxt = cnt_cur + 1'b1;
              end
            end
          end
          ModeOneshot: begin
            if (rise && !done_q[i]) begin
              if (cnt_cur >= n_val) begin
                cnt_nxt  = '0;
                done_nxt = 1'b1;
                term_nxt = 1'b1;
              end else begin
                cnt_nxt = cnt_cur + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end

    assign cnt_d[i*CNT_W +: CNT_W] = cnt_nxt;
    assign done_d[i]               = done_nxt;
    assign term[i]                 = term_nxt;
  end

  // Gates only mask the pulse; counters and done flags advance regardless.
  always_comb begin
    evt_out_d = term & {NCH{gate}};
    pend_d    = evt_out_d | (pend_q & ~pend_clr);
    irq_d     = |pend_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      // Tracking evt_in during reset stops a level held high from looking like a rise.
      evt_prev_q <= evt_in;
      mode_q     <= '0;
      cnt_q      <= '0;
      done_q     <= '0;
      pend_q     <= '0;
      evt_out_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      evt_prev_q <= evt_in;
      mode_q     <= mode;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      pend_q     <= pend_d;
      evt_out_q  <= evt_out_d;
      irq_q      <= irq_d;
    end
  end

  assign evt_out = evt_out_q;
  assign evt_cnt = cnt_q;
  assign done    = done_q;
  assign pend    = pend_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_event_decimator.sv
// Scenario bench for event_decimator: expected fire vectors are queued as rises are driven
// and popped when the registered evt_out is sampled.
module tb_event_decimator;

  localparam int unsigned NCH   = 8;
  localparam int unsigned CNT_W = 8;

  logic                 clk;
  logic                 reset;
  logic [NCH-1:0]       evt_in;
  logic                 pwm_onoff, int_onoff, carr_onoff;
  logic [2*NCH-1:0]     mode;
  logic [CNT_W*NCH-1:0] event_count;
  logic [NCH-1:0]       rearm, pend_clr;
  logic [NCH-1:0]       evt_out;
  logic [CNT_W*NCH-1:0] evt_cnt;
  logic [NCH-1:0]       done, pend;
  logic                 irq;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;
  logic [NCH-1:0] sb_q[$];
  logic [NCH-1:0] exp_v;

  event_decimator #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .evt_in      (evt_in),
    .pwm_onoff   (pwm_onoff),
    .int_onoff   (int_onoff),
    .carr_onoff  (carr_onoff),
    .mode        (mode),
    .event_count (event_count),
    .rearm       (rearm),
    .pend_clr    (pend_clr),
    .evt_out     (evt_out),
    .evt_cnt     (evt_cnt),
    .done        (done),
    .pend        (pend),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [1:0] m, input logic [CNT_W-1:0] n);
    mode[2*ch +: 2]            = m;
    event_count[ch*CNT_W +: CNT_W] = n;
  endtask

  // Drop evt_in for a cycle, then raise the masked channels with clr applied on that edge.
  task automatic apply_rise(input logic [NCH-1:0] mask, input logic [NCH-1:0] clr,
                            input logic [NCH-1:0] exp);
    evt_in = '0;
    step();
    evt_in   = mask;
    pend_clr = clr;
    sb_q.push_back(exp);
    step();
    pend_clr = '0;
  endtask

  function automatic logic [CNT_W-1:0] cnt_of(input int ch);
    return evt_cnt[ch*CNT_W +: CNT_W];
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    evt_in = '1;
    mode = {NCH{2'b01}};
    step();
    step();
    vec_cnt++; if (evt_out !== '0) begin err_cnt++; $display("FAIL reset_evt_out got %h exp 0", evt_out); end
    vec_cnt++; if (pend !== '0) begin err_cnt++; $display("FAIL reset_pend got %h exp 0", pend); end
    vec_cnt++; if (irq !== 1'b0) begin err_cnt++; $display("FAIL reset_irq got %b exp 0", irq); end
    vec_cnt++; if (done !== '0) begin err_cnt++; $display("FAIL reset_done got %h exp 0", done); end
    vec_cnt++; if (evt_cnt !== '0) begin err_cnt++; $display("FAIL reset_cnt got %h exp 0", evt_cnt); end
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sb_q.push_back('0);
      step();
      exp_v = sb_q.pop_front();
      vec_cnt++;
      if (evt_out !== exp_v) begin err_cnt++; $display("FAIL held_high_no_fire got %h exp %h", evt_out, exp_v); end
    end
    evt_in = '0;
    step();
  endtask

  task automatic test_decimate();
    set_ch(0, 2'd2, 8'd3);
    pend_clr = '1;
    step();
    pend_clr = '0;
    for (int k = 1; k <= 8; k++) begin
      apply_rise(8'h01, 8'h00, (k % 4 == 0) ? 8'h01 : 8'h00);
      exp_v = sb_q.pop_front();
      vec_cnt++;
      if (evt_out !== exp_v) begin err_cnt++; $display("FAIL dec_fire rise %0d got %h exp %h", k, evt_out, exp_v); end
      vec_cnt++;
      if (cnt_of(0) !== 8'(k % 4)) begin
        err_cnt++; $display("FAIL dec_cnt rise %0d got %0d exp %0d", k, cnt_of(0), k % 4);
      end
    end
    vec_cnt++; if (pend !== 8'h01) begin err_cnt++; $display("FAIL dec_pend got %h exp 01", pend); end
    vec_cnt++; if (irq !== 1'b1) begin err_cnt++; $display("FAIL dec_irq got %b exp 1", irq); end
  endtask

  task automatic test_oneshot();
    logic [CNT_W-1:0] exp_c [5] = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    set_ch(1, 2'd3, 8'd1);
    step();
    for (int k = 0; k < 5; k++) begin
      apply_rise(8'h02, 8'h00, (k == 1) ? 8'h02 : 8'h00);
      exp_v = sb_q.pop_front();
      vec_cnt++;
      if (evt_out !== exp_v) begin err_cnt++; $display("FAIL os_fire rise %0d got %h exp %h", k + 1, evt_out, exp_v); end
      vec_cnt++;
      if (cnt_of(1) !== exp_c[k]) begin
        err_cnt++; $display("FAIL os_cnt rise %0d got %0d exp %0d", k + 1, cnt_of(1), exp_c[k]);
      end
    end
    vec_cnt++; if (done[1] !== 1'b1) begin err_cnt++; $display("FAIL os_done got %b exp 1", done[1]); end
    evt_in = '0;
    rearm = 8'h02;
    step();
    rearm = '0;
    vec_cnt++; if (done[1] !== 1'b0) begin err_cnt++; $display("FAIL os_rearm_done got %b exp 0", done[1]); end
    for (int k = 0; k < 2; k++) begin
      apply_rise(8'h02, 8'h00, (k == 1) ? 8'h02 : 8'h00);
      exp_v = sb_q.pop_front();
      vec_cnt++;
      if (evt_out !== exp_v) begin err_cnt++; $display("FAIL os_rearm_fire rise %0d got %h exp %h", k + 1, evt_out, exp_v); end
    end
    vec_cnt++; if (done[1] !== 1'b1) begin err_cnt++; $display("FAIL os_done2 got %b exp 1", done[1]); end
  endtask

  task automatic test_lower_n();
    set_ch(2, 2'd2, 8'd5);
    step();
    for (int k = 1; k <= 4; k++) begin
      apply_rise(8'h04, 8'h00, 8'h00);
      exp_v = sb_q.pop_front();
      vec_cnt++;
      if (evt_out !== exp_v) begin err_cnt++; $display("FAIL lown_fire rise %0d got %h exp %h", k, evt_out, exp_v); end
    end
    vec_cnt++; if (cnt_of(2) !== 8'd4) begin err_cnt++; $display("FAIL lown_cnt4 got %0d exp 4", cnt_of(2)); end
    set_ch(2, 2'd2, 8'd2);
    apply_rise(8'h04, 8'h00, 8'h04);
    exp_v = sb_q.pop_front();
    vec_cnt++; if (evt_out !== exp_v) begin err_cnt++; $display("FAIL lown_wrap_fire got %h exp %h", evt_out, exp_v); end
    vec_cnt++; if (cnt_of(2) !== 8'd0) begin err_cnt++; $display("FAIL lown_wrap_cnt got %0d exp 0", cnt_of(2)); end
  endtask

  task automatic test_gates();
    set_ch(3, 2'd1, 8'd0);
    set_ch(4, 2'd2, 8'd1);
    int_onoff = 1'b0;
    pend_clr = '1;
    step();
    pend_clr = '0;
    for (int k = 0; k < 3; k++) begin
      apply_rise(8'h08, 8'h00, 8'h00);
      exp_v = sb_q.pop_front();
      vec_cnt++;
      if (evt_out !== exp_v) begin err_cnt++; $display("FAIL gate_off_fire got %h exp %h", evt_out, exp_v); end
    end
    vec_cnt++; if (pend !== '0) begin err_cnt++; $display("FAIL gate_off_pend got %h exp 0", pend); end
    vec_cnt++; if (irq !== 1'b0) begin err_cnt++; $display("FAIL gate_off_irq got %b exp 0", irq); end
    // Suppressed terminal rise must still wrap the counter.
    apply_rise(8'h10, 8'h00, 8'h00);
    void'(sb_q.pop_front());
    vec_cnt++; if (cnt_of(4) !== 8'd1) begin err_cnt++; $display("FAIL gate_off_cnt1 got %0d exp 1", cnt_of(4)); end
    apply_rise(8'h10, 8'h00, 8'h00);
    exp_v = sb_q.pop_front();
    vec_cnt++; if (evt_out !== exp_v) begin err_cnt++; $display("FAIL gate_off_wrap_fire got %h exp %h", evt_out, exp_v); end
    vec_cnt++; if (cnt_of(4) !== 8'd0) begin err_cnt++; $display("FAIL gate_off_wrap_cnt got %0d exp 0", cnt_of(4)); end
    int_onoff = 1'b1;
    apply_rise(8'h08, 8'h00, 8'h08);
    exp_v = sb_q.pop_front();
    vec_cnt++; if (evt_out !== exp_v) begin err_cnt++; $display("FAIL gate_on_fire got %h exp %h", evt_out, exp_v); end
    vec_cnt++; if (pend !== 8'h08) begin err_cnt++; $display("FAIL gate_on_pend got %h exp 08", pend); end
    vec_cnt++; if (irq !== 1'b1) begin err_cnt++; $display("FAIL gate_on_irq got %b exp 1", irq); end
    step();
    vec_cnt++; if (evt_out !== '0) begin err_cnt++; $display("FAIL gate_on_pulse_width got %h exp 0", evt_out); end
    pend_clr = 8'h08;
    step();
    pend_clr = '0;
    vec_cnt++; if (pend !== '0) begin err_cnt++; $display("FAIL pend_clr_pend got %h exp 0", pend); end
    vec_cnt++; if (irq !== 1'b0) begin err_cnt++; $display("FAIL pend_clr_irq got %b exp 0", irq); end
  endtask

  task automatic test_back_to_back();
    mode = {NCH{2'b01}};
    pend_clr = '1;
    step();
    pend_clr = '0;
    apply_rise(8'hFF, 8'h04, 8'hFF);
    exp_v = sb_q.pop_front();
    vec_cnt++; if (evt_out !== exp_v) begin err_cnt++; $display("FAIL b2b_fire got %h exp %h", evt_out, exp_v); end
    vec_cnt++; if (pend !== 8'hFF) begin err_cnt++; $display("FAIL b2b_pend got %h exp ff", pend); end
    vec_cnt++; if (irq !== 1'b1) begin err_cnt++; $display("FAIL b2b_irq got %b exp 1", irq); end
  endtask

  task automatic test_reset_mid();
    set_ch(0, 2'd2, 8'd5);
    step();
    apply_rise(8'h01, 8'h00, 8'h00);
    void'(sb_q.pop_front());
    apply_rise(8'h01, 8'h00, 8'h00);
    void'(sb_q.pop_front());
    vec_cnt++; if (cnt_of(0) !== 8'd2) begin err_cnt++; $display("FAIL mid_cnt2 got %0d exp 2", cnt_of(0)); end
    reset = 1'b0;
    evt_in = '0;
    step();
    vec_cnt++;
    if ({evt_out, pend, done, irq} !== '0 || evt_cnt !== '0) begin
      err_cnt++;
      $display("FAIL mid_reset_outs got out=%h pend=%h done=%h irq=%b cnt=%h exp all 0",
               evt_out, pend, done, irq, evt_cnt);
    end
    reset = 1'b1;
    step();
    apply_rise(8'h01, 8'h00, 8'h00);
    void'(sb_q.pop_front());
    vec_cnt++; if (cnt_of(0) !== 8'd1) begin err_cnt++; $display("FAIL mid_restart_cnt got %0d exp 1", cnt_of(0)); end
    // Mode switch coincident with a rise: count cleared, rise discarded.
    evt_in = '0;
    step();
    set_ch(0, 2'd3, 8'd0);
    evt_in = 8'h01;
    sb_q.push_back('0);
    step();
    exp_v = sb_q.pop_front();
    vec_cnt++; if (evt_out !== exp_v) begin err_cnt++; $display("FAIL modechg_fire got %h exp %h", evt_out, exp_v); end
    vec_cnt++; if (cnt_of(0) !== 8'd0) begin err_cnt++; $display("FAIL modechg_cnt got %0d exp 0", cnt_of(0)); end
  endtask

  initial begin
    reset = 1'b0;
    evt_in = '0;
    pwm_onoff = 1'b1;
    int_onoff = 1'b1;
    carr_onoff = 1'b1;
    mode = '0;
    event_count = '0;
    rearm = '0;
    pend_clr = '0;
    test_reset();
    test_decimate();
    test_oneshot();
    test_lower_n();
    test_gates();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
